// File: rtl/stim_pkg.sv
// Shared types and opcode field layout for the b12 stimulus sequencer.
package stim_pkg;

  localparam int unsigned OP_W      = 6;
  localparam int unsigned OBS_BIT   = 5;
  localparam int unsigned K_HI      = 4;
  localparam int unsigned K_LO      = 1;
  localparam int unsigned START_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/stim_ram.sv
// Program store: register array with synchronous write and combinational read.
module stim_ram
  import stim_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [OP_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [OP_W-1:0] rdata_c
);

  // Contents are deliberately not reset; len gates reachability.
  logic [OP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/stim_sequencer.sv
// Loads a short opcode program, replays it onto the b12 inputs, and monitors b12 outputs.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [OP_W-1:0] load_data,
  input  logic            load_last,
  input  logic            run,
  input  logic            stop,
  input  logic            loop_en,
  output logic            obs,
  output logic [3:0]      k,
  output logic            start,
  input  logic            nloss_in,
  input  logic [3:0]      nl_in,
  input  logic            speaker_in,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [AW:0]     len,
  output logic [AW-1:0]   pc,
  output logic [7:0]      loss_cnt,
  output logic            spk_seen
);

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [7:0]      loss_q, loss_d;
  logic            spk_q, spk_d;
  logic            nloss_prev_q, nloss_prev_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  logic            we_c;
  logic [AW-1:0]   waddr_c;
  logic [AW-1:0]   raddr_c;
  logic [OP_W-1:0] rdata_c;

  // nl_in is only observed externally.
  logic unused_nl;
  assign unused_nl = ^nl_in;

  stim_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock   (clock),
    .we      (we_c),
    .waddr   (waddr_c),
    .wdata   (load_data),
    .raddr   (raddr_c),
    .rdata_c (rdata_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      pc_q         <= '0;
      ovf_q        <= 1'b0;
      op_q         <= '0;
      loss_q       <= '0;
      spk_q        <= 1'b0;
      nloss_prev_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pc_q         <= pc_d;
      ovf_q        <= ovf_d;
      op_q         <= op_d;
      loss_q       <= loss_d;
      spk_q        <= spk_d;
      nloss_prev_q <= nloss_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pc_d         = pc_q;
    ovf_d        = ovf_q;
    op_d         = '0;
    loss_d       = loss_q;
    spk_d        = spk_q;
    nloss_prev_d = nloss_in;
    we_c         = 1'b0;
    waddr_c      = len_q[AW-1:0];
    raddr_c      = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // A fresh load restarts the program at address 0 and wins over run.
        if (load_valid) begin
          we_c    = 1'b1;
          waddr_c = '0;
          len_d   = (AW+1)'(1);
          ovf_d   = 1'b0;
          state_d = load_last ? ST_IDLE : ST_LOAD;
        end else if (run && (len_q != '0)) begin
          op_d    = rdata_c;
          pc_d    = (AW+1)'(1);
          loss_d  = '0;
          spk_d   = 1'b0;
          state_d = ST_PLAY;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          if (len_q == FULL_LEN) begin
            ovf_d = 1'b1;
          end else begin
            we_c  = 1'b1;
            len_d = len_q + (AW+1)'(1);
          end
          if (load_last) state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        // pc == len means the final entry went out on the previous edge.
        if (stop) begin
          pc_d    = '0;
          state_d = ST_IDLE;
        end else if (pc_q == len_q) begin
          if (loop_en) begin
            op_d = rdata_c;
            pc_d = (AW+1)'(1);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          raddr_c = pc_q[AW-1:0];
          op_d    = rdata_c;
          pc_d    = pc_q + (AW+1)'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_PLAY) begin
      if (nloss_prev_q && !nloss_in && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
      if (speaker_in) spk_d = 1'b1;
    end

    busy_d  = (state_d == ST_PLAY);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d != ST_PLAY);
  end

  assign load_ready = ready_q;
  assign obs        = op_q[OBS_BIT];
  assign k          = op_q[K_HI:K_LO];
  assign start      = op_q[START_BIT];
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign len        = len_q;
  assign pc         = pc_q[AW-1:0];
  assign loss_cnt   = loss_q;
  assign spk_seen   = spk_q;

endmodule
